// File: rtl/iqmap_seq_ctrl.sv
// Frame sequencer feeding a BPSK mapper: pops 128-bit words from a FIFO
// and emits them one bit per symbol-rate enable, LSB first.
module iqmap_seq_ctrl #(
  parameter int FRAME_WORDS = 4
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         start,
  input  logic         abort,
  input  logic         ce,
  input  logic         fifo_empty,
  input  logic [127:0] fifo_data,
  output logic         fifo_rd_en,
  output logic         load,
  output logic         bit_out,
  output logic         bit_valid,
  output logic [6:0]   bit_idx,
  output logic         busy,
  output logic         done,
  output logic         underrun
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_LOAD  = 3'd3;
  localparam logic [2:0] S_SHIFT = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam logic [7:0] FW = 8'(FRAME_WORDS);

  logic [2:0]   state;
  logic [2:0]   state_nx;
  logic [7:0]   words;
  logic [6:0]   idx;
  logic [127:0] word;
  logic         last;

  assign last       = ce && (idx == 7'd127);
  assign fifo_rd_en = (state == S_FETCH) && !fifo_empty;
  assign load       = (state == S_LOAD);
  assign busy       = (state != S_IDLE);
  assign done       = (state == S_DONE);

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (start) state_nx = S_FETCH;
      S_FETCH: if (!fifo_empty) state_nx = S_WAIT;
      S_WAIT:  state_nx = S_LOAD;
      S_LOAD:  state_nx = S_SHIFT;
      S_SHIFT: if (last) state_nx = (words == 8'd1) ? S_DONE : S_FETCH;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
    if (abort) state_nx = S_IDLE;
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state     <= S_IDLE;
      words     <= 8'd0;
      idx       <= 7'd0;
      word      <= '0;
      bit_out   <= 1'b0;
      bit_valid <= 1'b0;
      bit_idx   <= 7'd0;
      underrun  <= 1'b0;
    end else begin
      state     <= state_nx;
      bit_valid <= 1'b0;
      if (state == S_IDLE && start && !abort) begin
        words    <= FW;
        underrun <= 1'b0;
      end
      // only a starved word after the first counts as an underrun
      if (state == S_FETCH && fifo_empty && !abort && words != FW)
        underrun <= 1'b1;
      if (state == S_LOAD) begin
        word <= fifo_data;
        idx  <= 7'd0;
      end
      if (state == S_SHIFT && ce && !abort) begin
        bit_valid <= 1'b1;
        bit_out   <= word[idx];
        bit_idx   <= idx;
        idx       <= idx + 7'd1;
        if (idx == 7'd127) words <= words - 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_iqmap_seq_ctrl.sv
// Scoreboard bench for iqmap_seq_ctrl: one- and four-word frame instances
// share a FIFO model; a monitor pops expected bits as they appear.
module tb_iqmap_seq_ctrl;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  logic start1 = 1'b0, start4 = 1'b0;
  logic abort = 1'b0, ce = 1'b0, hold = 1'b0;
  logic tog = 1'b0, sel = 1'b0;
  logic [127:0] fifo_data = '0;
  logic [127:0] mem [0:15];
  int rp = 0, wp = 0;
  logic fifo_empty;

  logic rd1, ld1, bo1, bv1, busy1, done1, ur1;
  logic rd4, ld4, bo4, bv4, busy4, done4, ur4;
  logic [6:0] bi1, bi4;
  logic m_rd, m_ld, m_bo, m_bv, m_busy, m_done, m_ur;
  logic [6:0] m_bi;

  int checks = 0, errors = 0;
  int n_rd = 0, n_ld = 0, n_done = 0, n_bits = 0, n_b2b = 0;
  logic prev_bv = 1'b0;
  logic [7:0] eq [$];

  localparam logic [127:0] W_A = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [127:0] W_B = {4{32'hA5A5_0F0F}};
  localparam logic [127:0] W_C = {1'b1, 126'd0, 1'b1};
  localparam logic [127:0] W_D = ~W_A;

  always #5 CLK = ~CLK;

  assign fifo_empty = hold || (rp == wp);

  always @(posedge CLK)
    if (rd1 || rd4) begin
      fifo_data <= mem[rp[3:0]];
      rp <= rp + 1;
    end

  iqmap_seq_ctrl #(.FRAME_WORDS(1)) u1 (
    .CLK(CLK), .RST(RST), .start(start1), .abort(abort), .ce(ce),
    .fifo_empty(fifo_empty), .fifo_data(fifo_data), .fifo_rd_en(rd1),
    .load(ld1), .bit_out(bo1), .bit_valid(bv1), .bit_idx(bi1),
    .busy(busy1), .done(done1), .underrun(ur1));

  iqmap_seq_ctrl #(.FRAME_WORDS(4)) u4 (
    .CLK(CLK), .RST(RST), .start(start4), .abort(abort), .ce(ce),
    .fifo_empty(fifo_empty), .fifo_data(fifo_data), .fifo_rd_en(rd4),
    .load(ld4), .bit_out(bo4), .bit_valid(bv4), .bit_idx(bi4),
    .busy(busy4), .done(done4), .underrun(ur4));

  assign m_rd   = sel ? rd4   : rd1;
  assign m_ld   = sel ? ld4   : ld1;
  assign m_bo   = sel ? bo4   : bo1;
  assign m_bv   = sel ? bv4   : bv1;
  assign m_bi   = sel ? bi4   : bi1;
  assign m_busy = sel ? busy4 : busy1;
  assign m_done = sel ? done4 : done1;
  assign m_ur   = sel ? ur4   : ur1;

  task automatic chk(input string nm, input logic [127:0] got,
                     input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, got, exp);
    end
  endtask

  task automatic run_monitor();
    logic [7:0] e;
    forever begin
      @(negedge CLK);
      if (m_rd) n_rd++;
      if (m_ld) n_ld++;
      if (m_done) n_done++;
      if (m_bv) begin
        n_bits++;
        if (prev_bv) n_b2b++;
        checks++;
        if (eq.size() == 0) begin
          errors++;
          $display("FAIL bit_extra got idx=%0d bit=%0b want none", m_bi, m_bo);
        end else begin
          e = eq.pop_front();
          if ({m_bi, m_bo} !== e) begin
            errors++;
            $display("FAIL bit got idx=%0d bit=%0b want idx=%0d bit=%0b",
                     m_bi, m_bo, e[7:1], e[0]);
          end
        end
      end
      prev_bv = m_bv;
    end
  endtask

  task automatic tick();
    @(negedge CLK);
    #1;
    if (tog) ce = ~ce;
  endtask

  task automatic clr_cnt();
    n_rd = 0; n_ld = 0; n_done = 0; n_bits = 0; n_b2b = 0;
  endtask

  task automatic put(input logic [127:0] w);
    mem[wp[3:0]] = w;
    wp++;
  endtask

  task automatic expect_bits(input logic [127:0] w, input int n);
    for (int i = 0; i < n; i++) eq.push_back({7'(i), w[i]});
  endtask

  task automatic pulse_start();
    if (sel) start4 = 1'b1; else start1 = 1'b1;
    tick();
    start1 = 1'b0;
    start4 = 1'b0;
  endtask

  task automatic wait_done(input string nm, output int cyc);
    cyc = 1;
    while (!m_done && cyc < 3000) begin
      tick();
      cyc++;
    end
    if (!m_done) chk({nm, "_timeout"}, 1'b1, 1'b0);
  endtask

  task automatic wait_bits(input string nm, input int target);
    int k = 0;
    while (n_bits < target && k < 3000) begin
      tick();
      k++;
    end
    if (n_bits < target) chk({nm, "_timeout"}, 32'(n_bits), 32'(target));
  endtask

  task automatic end_frame(input string nm, input int nbits);
    int cyc;
    wait_done(nm, cyc);
    tick();
    chk({nm, "_bits"}, 32'(n_bits), 32'(nbits));
    chk({nm, "_done"}, 32'(n_done), 32'd1);
    chk({nm, "_busy"}, m_busy, 1'b0);
    chk({nm, "_left"}, 32'(eq.size()), 32'd0);
  endtask

  task automatic run_stim();
    int cyc;
    tick();
    tick();
    chk("rst_u1", {rd1, ld1, bo1, bv1, bi1, busy1, done1, ur1}, '0);
    chk("rst_u4", {rd4, ld4, bo4, bv4, bi4, busy4, done4, ur4}, '0);
    RST = 1'b1;
    ce = 1'b1;
    tick();

    // single word, single set bit
    sel = 1'b0; clr_cnt();
    put(128'h1); expect_bits(128'h1, 128);
    pulse_start();
    wait_done("t1", cyc);
    chk("t1_latency_ge130", cyc >= 130, 1'b1);
    tick();
    chk("t1_rd", 32'(n_rd), 32'd1);
    chk("t1_load", 32'(n_ld), 32'd1);
    chk("t1_bits", 32'(n_bits), 32'd128);
    chk("t1_b2b", 32'(n_b2b), 32'd127);
    chk("t1_busy", m_busy, 1'b0);

    // ce alternating, all-ones word
    clr_cnt();
    put('1); expect_bits('1, 128);
    tog = 1'b1;
    pulse_start();
    end_frame("t2", 128);
    chk("t2_b2b", 32'(n_b2b), 32'd0);
    tog = 1'b0; ce = 1'b1;

    // four words, FIFO starved before the last
    sel = 1'b1; clr_cnt();
    put(W_A); put(W_B); put(W_C);
    expect_bits(W_A, 128); expect_bits(W_B, 128);
    expect_bits(W_C, 128); expect_bits(W_D, 128);
    pulse_start();
    chk("t3_ur_first", m_ur, 1'b0);
    wait_bits("t3", 384);
    for (int i = 0; i < 10; i++) tick();
    chk("t3_stall_loads", 32'(n_ld), 32'd3);
    chk("t3_ur_set", m_ur, 1'b1);
    put(W_D);
    end_frame("t3", 512);
    chk("t3_ur_sticky", m_ur, 1'b1);

    // abort at bit 60 of the third word
    clr_cnt();
    put(W_B); put(W_C); put(W_A); put(W_D);
    expect_bits(W_B, 128); expect_bits(W_C, 128); expect_bits(W_A, 61);
    pulse_start();
    chk("t4_ur_clr", m_ur, 1'b0);
    for (int k = 0; k < 3000; k++) begin
      if (n_ld == 3 && m_bv && m_bi == 7'd60) break;
      tick();
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t4_busy", m_busy, 1'b0);
    chk("t4_bv", m_bv, 1'b0);
    for (int i = 0; i < 5; i++) tick();
    chk("t4_no_done", 32'(n_done), 32'd0);
    chk("t4_bits", 32'(n_bits), 32'd317);
    chk("t4_ur", m_ur, 1'b0);
    wp = rp;

    clr_cnt();
    put(W_D); put(W_A); put(W_B); put(W_C);
    expect_bits(W_D, 128); expect_bits(W_A, 128);
    expect_bits(W_B, 128); expect_bits(W_C, 128);
    pulse_start();
    end_frame("t4b", 512);
    chk("t4b_ur", m_ur, 1'b0);

    // start while busy is ignored
    clr_cnt();
    put(W_C); put(W_C); put(W_B); put(W_A);
    expect_bits(W_C, 128); expect_bits(W_C, 128);
    expect_bits(W_B, 128); expect_bits(W_A, 128);
    pulse_start();
    for (int i = 0; i < 50; i++) tick();
    pulse_start();
    end_frame("t5", 512);
    chk("t5_rd", 32'(n_rd), 32'd4);

    // reset mid-frame
    clr_cnt();
    put(W_A); put(W_B); put(W_C); put(W_D);
    expect_bits(W_A, 128); expect_bits(W_B, 128);
    expect_bits(W_C, 128); expect_bits(W_D, 128);
    pulse_start();
    wait_bits("t6", 200);
    RST = 1'b0;
    tick();
    chk("t6_rst_u4", {rd4, ld4, bo4, bv4, bi4, busy4, done4, ur4}, '0);
    chk("t6_no_done", 32'(n_done), 32'd0);
    eq.delete();
    wp = rp;
    RST = 1'b1;
    tick();

    clr_cnt();
    put(W_B); put(W_D); put(W_A); put(W_C);
    expect_bits(W_B, 128); expect_bits(W_D, 128);
    expect_bits(W_A, 128); expect_bits(W_C, 128);
    pulse_start();
    end_frame("t6b", 512);
    chk("t6b_ur", m_ur, 1'b0);
  endtask

  initial begin
    fork
      run_monitor();
      run_stim();
    join_any
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/iqmap_seq_ctrl.md
IQMAP_SEQ_CTRL -- requirements
Module: iqmap_seq_ctrl

Interface
REQ-001 The block SHALL have parameter FRAME_WORDS, default 4, meaning the number of 128-bit words per frame (range 1..255).
REQ-002 The block SHALL have port CLK  input  1  system clock; all state changes on its rising edge.
REQ-003 The block SHALL have port RST  input  1  reset; synchronous, active-low.
REQ-004 The block SHALL have port start  input  1  frame request, sampled only in IDLE.
REQ-005 The block SHALL have port abort  input  1  terminate the current frame.
REQ-006 The block SHALL have port ce  input  1  symbol-rate enable; one bit is emitted per SHIFT cycle with ce=1.
REQ-007 The block SHALL have port fifo_empty  input  1  source FIFO holds no word.
REQ-008 The block SHALL have port fifo_data  input  128  FIFO read data, valid one cycle after fifo_rd_en.
REQ-009 The block SHALL have port fifo_rd_en  output  1  one-cycle FIFO pop strobe.
REQ-010 The block SHALL have port load  output  1  one-cycle pulse: new word captured (drives mapper valid_i).
REQ-011 The block SHALL have port bit_out  output  1  current data bit to the BPSK mapper.
REQ-012 The block SHALL have port bit_valid  output  1  bit_out valid this cycle.
REQ-013 The block SHALL have port bit_idx  output  7  index of bit_out within its word.
REQ-014 The block SHALL have port busy  output  1  frame in progress (state not IDLE).
REQ-015 The block SHALL have port done  output  1  one-cycle pulse: frame completed normally.
REQ-016 The block SHALL have port underrun  output  1  sticky: FIFO was empty when a word was due mid-frame.

Function
REQ-017 The block SHALL implement states IDLE, FETCH, WAIT, LOAD, SHIFT, DONE.
REQ-018 IDLE: start=1 SHALL move to FETCH, load word counter with FRAME_WORDS, clear underrun; start in any other state SHALL be ignored.
REQ-019 FETCH: fifo_empty=0 SHALL assert fifo_rd_en for exactly that cycle and move to WAIT; fifo_empty=1 SHALL hold FETCH with fifo_rd_en=0.
REQ-020 FETCH held with fifo_empty=1 for a word other than the first of the frame SHALL set underrun, which stays 1 until the next accepted start or reset.
REQ-021 WAIT SHALL last one cycle and move to LOAD.
REQ-022 LOAD SHALL capture fifo_data into a 128-bit word register, pulse load=1, clear bit_idx to 0, and move to SHIFT.
REQ-023 SHIFT with ce=1 SHALL drive bit_valid=1, bit_out=word[bit_idx] in the following cycle (registered, latency 1), then increment bit_idx; ce=0 SHALL hold bit_idx and give bit_valid=0 the following cycle.
REQ-024 Bits SHALL be emitted LSB first, bit 0 through bit 127, exactly 128 per word, none skipped or repeated.
REQ-025 SHIFT with ce=1 and bit_idx=127 SHALL decrement the word counter; if the result is 0 move to DONE, else move to FETCH; bit_idx SHALL wrap to 0.
REQ-026 DONE SHALL pulse done=1 for one cycle and return to IDLE.
REQ-027 busy SHALL be 1 in every state except IDLE.
REQ-028 abort=1 in any state SHALL force IDLE on the next edge, deassert bit_valid next cycle, suppress done, and leave underrun unchanged; abort has priority over start and all other transitions.
REQ-029 abort coincident with fifo_rd_en SHALL still pop that word; the word is discarded.
REQ-030 bit_out and bit_idx SHALL hold their last value when bit_valid=0.

Reset
REQ-031 RST=0 at a rising edge SHALL force state IDLE, word counter 0, bit_idx 0, word register 0, and outputs fifo_rd_en=0, load=0, bit_out=0, bit_valid=0, busy=0, done=0, underrun=0.
REQ-032 Reset mid-frame SHALL discard all frame progress with no done pulse; the first start after release SHALL begin a fresh frame.

Verification
REQ-033 The bench SHALL cover: FRAME_WORDS=1, ce=1, word 128'h1 -> one fifo_rd_en, one load, 128 bit_valid with bit_out=1 only at bit_idx 0, done 130+ cycles after start, busy then 0.
REQ-034 The bench SHALL cover: ce toggling 1/0 each cycle, word all-ones -> 128 bit_valid pulses spaced 2 cycles, bit_idx strictly 0..127.
REQ-035 The bench SHALL cover: FRAME_WORDS=4, fifo_empty=1 for 10 cycles before word 3 -> FETCH stalls, underrun=1 sticky through done, 512 bits total.
REQ-036 The bench SHALL cover: abort at bit_idx=60 of word 2 -> IDLE next cycle, no done, bit_valid=0; a new start gives a full frame with underrun=0.
REQ-037 The bench SHALL cover: start pulsed while busy -> ignored, frame length unchanged; RST=0 mid-SHIFT -> all outputs 0 next cycle.
